pulse_burst_sched: RTL and testbench

- Shared pulse-generator controller. Arbitrates one internal free-running divider among NREQ requesters.
- Each requester asks for a burst of LEN pulses at a divide ratio of 2, 4, 8 or 16.
- Grants are round-robin. The block sequences the divider for the granted requester and returns a one-cycle done.
- Used as a switching-activity stimulus source for power-trace examples.

---
 rtl/pulse_burst_sched_if.sv | 25 ++
 rtl/pulse_burst_sched.sv | 143 ++++++++++++++
 tb/tb_pulse_burst_sched.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/pulse_burst_sched_if.sv
// Bundle of request and status signals between requesters and the shared pulse scheduler.
// The requester side drives the request/configuration fields; the scheduler drives grant and status.
interface pulse_burst_sched_if #(
   parameter int NREQ  = 4,
   parameter int LEN_W = 8
);
   logic [NREQ-1:0]       req;
   logic [2*NREQ-1:0]     div_sel;
   logic [LEN_W*NREQ-1:0] len;
   logic [NREQ-1:0]       grant;
   logic                  busy;
   logic                  pulse_out;
   logic [LEN_W-1:0]      pulse_cnt;
   logic [NREQ-1:0]       done;

   modport master (
      output req, div_sel, len,
      input  grant, busy, pulse_out, pulse_cnt, done
   );

   modport slave (
      input  req, div_sel, len,
      output grant, busy, pulse_out, pulse_cnt, done
   );
endinterface

// File: rtl/pulse_burst_sched.sv
// Shared pulse-generator controller: round-robin arbitration of one 4-bit divider among
// NREQ requesters, each asking for a burst of LEN pulses at /2, /4, /8 or /16.
module pulse_burst_sched #(
   parameter int NREQ  = 4,
   parameter int LEN_W = 8
) (
   input  logic                clk,
   input  logic                rst,
   pulse_burst_sched_if.slave  bus
);
   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q;
   logic [NREQ-1:0]  grant_q;
   logic [NREQ-1:0]  done_q;
   logic [3:0]       cnt_q;
   logic [3:0]       mask_q;
   logic [LEN_W-1:0] pulse_cnt_q;
   logic [LEN_W-1:0] blen_q;
   logic [IW-1:0]    last_q;
   logic [IW-1:0]    idx_q;

   logic             anyReq_d;
   logic [IW-1:0]    selIdx_d;
   logic [IW:0]      candSum;
   logic [IW-1:0]    candIdx;
   logic [1:0]       selDiv_d;
   logic [3:0]       selMask_d;
   logic [LEN_W-1:0] selLen_d;
   logic             pulse;
   logic             lastPulse;

   // Round-robin search: first requesting index starting just after the last served one.
   always_comb begin
      anyReq_d = 1'b0;
      selIdx_d = '0;
      candSum  = '0;
      candIdx  = '0;
      for (int k = 1; k <= NREQ; k++) begin
         candSum = {1'b0, last_q} + (IW+1)'(k);
         if (candSum >= (IW+1)'(NREQ)) begin
            candSum = candSum - (IW+1)'(NREQ);
         end
         candIdx = candSum[IW-1:0];
         if (!anyReq_d && bus.req[candIdx]) begin
            anyReq_d = 1'b1;
            selIdx_d = candIdx;
         end
      end
   end

   // Pick out the divide select and burst length of the winning requester and form its mask.
   always_comb begin
      selDiv_d = '0;
      selLen_d = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (selIdx_d == IW'(i)) begin
            selDiv_d = bus.div_sel[2*i +: 2];
            selLen_d = bus.len[LEN_W*i +: LEN_W];
         end
      end
      case (selDiv_d)
         2'd0:    selMask_d = 4'd1;
         2'd1:    selMask_d = 4'd3;
         2'd2:    selMask_d = 4'd7;
         default: selMask_d = 4'd15;
      endcase
   end

   // A pulse fires whenever all masked counter bits are set; the final one ends the burst.
   always_comb begin
      pulse     = (state_q == RUN) && ((cnt_q & mask_q) == mask_q);
      lastPulse = pulse && (pulse_cnt_q == (blen_q - LEN_W'(1)));
   end

   // Burst sequencer: grant, run the divider, then strobe done or abort back to idle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         grant_q     <= '0;
         done_q      <= '0;
         cnt_q       <= '0;
         mask_q      <= '0;
         pulse_cnt_q <= '0;
         blen_q      <= '0;
         last_q      <= IW'(NREQ-1);
         idx_q       <= '0;
      end else begin
         done_q <= '0;
         case (state_q)
            IDLE: begin
               if (anyReq_d) begin
                  idx_q       <= selIdx_d;
                  mask_q      <= selMask_d;
                  blen_q      <= selLen_d;
                  cnt_q       <= '0;
                  pulse_cnt_q <= '0;
                  if (selLen_d == '0) begin
                     state_q <= DONE;
                     grant_q <= '0;
                     done_q  <= NREQ'(1) << selIdx_d;
                  end else begin
                     state_q <= RUN;
                     grant_q <= NREQ'(1) << selIdx_d;
                  end
               end
            end
            RUN: begin
               cnt_q <= cnt_q + 4'd1;
               if (pulse) begin
                  pulse_cnt_q <= pulse_cnt_q + LEN_W'(1);
               end
               if (lastPulse) begin
                  state_q <= DONE;
                  grant_q <= '0;
                  done_q  <= NREQ'(1) << idx_q;
               end else if (!bus.req[idx_q]) begin
                  state_q <= IDLE;
                  grant_q <= '0;
                  last_q  <= idx_q;
               end
            end
            DONE: begin
               last_q  <= idx_q;
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
               grant_q <= '0;
            end
         endcase
      end
   end

   assign bus.grant     = grant_q;
   assign bus.done      = done_q;
   assign bus.busy      = (state_q != IDLE);
   assign bus.pulse_out = pulse;
   assign bus.pulse_cnt = pulse_cnt_q;

endmodule

// File: tb/tb_pulse_burst_sched.sv
// Directed bench for the shared pulse scheduler: single bursts, /16, zero length,
// abort, asynchronous reset mid-burst and round-robin rotation.
module tb_pulse_burst_sched;
   logic clk;
   logic rst;
   int   errCount;
   int   checkCount;

   pulse_burst_sched_if #(.NREQ(4), .LEN_W(8)) bus ();

   pulse_burst_sched #(.NREQ(4), .LEN_W(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Free-running 100 MHz clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checkCount++;
      if (got !== exp) begin
         errCount++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic applyStimulus(input logic [3:0] r, input logic [7:0] dv, input logic [31:0] ln);
      bus.req     = r;
      bus.div_sel = dv;
      bus.len     = ln;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkIdle(input string tag, input int pcnt);
      checkOutput({tag, " idle grant"}, 32'(bus.grant), 32'd0);
      checkOutput({tag, " idle done"}, 32'(bus.done), 32'd0);
      checkOutput({tag, " idle busy"}, 32'(bus.busy), 32'd0);
      checkOutput({tag, " idle pcnt"}, 32'(bus.pulse_cnt), 32'(pcnt));
   endtask

   // Expects the scheduler idle with the request already driven; covers grant through done.
   task automatic runBurst(input int idx, input int dv, input int ln, input string tag);
      int p;
      int n;
      p = 2 << dv;
      n = ln * p;
      tick();
      for (int c = 1; c <= n; c++) begin
         checkOutput({tag, " grant"}, 32'(bus.grant), 32'(1 << idx));
         checkOutput({tag, " pulse"}, 32'(bus.pulse_out), 32'((c % p) == 0));
         checkOutput({tag, " pcnt"}, 32'(bus.pulse_cnt), 32'((c - 1) / p));
         tick();
      end
      checkOutput({tag, " done"}, 32'(bus.done), 32'(1 << idx));
      checkOutput({tag, " done grant"}, 32'(bus.grant), 32'd0);
      checkOutput({tag, " done busy"}, 32'(bus.busy), 32'd1);
      checkOutput({tag, " done pulse"}, 32'(bus.pulse_out), 32'd0);
      checkOutput({tag, " done pcnt"}, 32'(bus.pulse_cnt), 32'(ln));
   endtask

   // Main directed sequence.
   initial begin
      errCount   = 0;
      checkCount = 0;
      rst        = 1'b0;
      applyStimulus(4'b0000, 8'h00, 32'h0);
      #12;
      checkOutput("rst grant", 32'(bus.grant), 32'd0);
      checkOutput("rst done", 32'(bus.done), 32'd0);
      checkOutput("rst busy", 32'(bus.busy), 32'd0);
      checkOutput("rst pulse", 32'(bus.pulse_out), 32'd0);
      checkOutput("rst pcnt", 32'(bus.pulse_cnt), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      tick();

      applyStimulus(4'b0001, 8'h00, 32'h0000_0003);
      runBurst(0, 0, 3, "single");
      applyStimulus(4'b0000, 8'h00, 32'h0000_0003);
      tick();
      checkIdle("single", 3);

      applyStimulus(4'b0001, 8'h03, 32'h0000_0002);
      runBurst(0, 3, 2, "div16");
      applyStimulus(4'b0000, 8'h03, 32'h0000_0002);
      tick();
      checkIdle("div16", 2);

      applyStimulus(4'b0010, 8'h00, 32'h0000_0000);
      runBurst(1, 0, 0, "zerolen");
      applyStimulus(4'b0000, 8'h00, 32'h0000_0000);
      tick();
      checkIdle("zerolen", 0);

      applyStimulus(4'b0100, 8'h10, 32'h0105_0001);
      tick();
      for (int c = 1; c <= 8; c++) begin
         checkOutput("abort grant", 32'(bus.grant), 32'h4);
         checkOutput("abort pulse", 32'(bus.pulse_out), 32'((c % 4) == 0));
         checkOutput("abort pcnt", 32'(bus.pulse_cnt), 32'((c - 1) / 4));
         if (c < 8) tick();
      end
      applyStimulus(4'b1001, 8'h10, 32'h0105_0001);
      tick();
      checkIdle("abort", 2);
      runBurst(3, 0, 1, "after abort r3");
      applyStimulus(4'b0001, 8'h10, 32'h0105_0001);
      tick();
      checkIdle("after abort r3", 1);
      runBurst(0, 0, 1, "after abort r0");
      applyStimulus(4'b0000, 8'h00, 32'h0);
      tick();
      checkIdle("after abort r0", 1);

      applyStimulus(4'b0001, 8'h03, 32'd10);
      tick();
      repeat (20) tick();
      checkOutput("midrun pcnt", 32'(bus.pulse_cnt), 32'd1);
      checkOutput("midrun busy", 32'(bus.busy), 32'd1);
      #3;
      rst = 1'b0;
      #1;
      checkOutput("async grant", 32'(bus.grant), 32'd0);
      checkOutput("async busy", 32'(bus.busy), 32'd0);
      checkOutput("async pulse", 32'(bus.pulse_out), 32'd0);
      checkOutput("async pcnt", 32'(bus.pulse_cnt), 32'd0);
      applyStimulus(4'b0000, 8'h00, 32'h0);
      #2;
      rst = 1'b1;
      tick();

      applyStimulus(4'b1111, 8'h00, 32'h0101_0101);
      runBurst(0, 0, 1, "rr first r0");
      applyStimulus(4'b1110, 8'h00, 32'h0101_0101);
      tick();
      checkIdle("rr r0", 1);
      runBurst(1, 0, 1, "rr r1");
      applyStimulus(4'b1101, 8'h00, 32'h0101_0101);
      tick();
      checkIdle("rr r1", 1);
      runBurst(2, 0, 1, "rr r2");
      applyStimulus(4'b1011, 8'h00, 32'h0101_0101);
      tick();
      checkIdle("rr r2", 1);
      runBurst(3, 0, 1, "rr r3");
      applyStimulus(4'b0111, 8'h00, 32'h0101_0101);
      tick();
      checkIdle("rr r3", 1);
      runBurst(0, 0, 1, "rr second r0");
      applyStimulus(4'b0000, 8'h00, 32'h0);
      tick();
      checkIdle("rr end", 1);

      $display("Result: errors=%0d of %0d checks", errCount, checkCount);
      $finish;
   end
endmodule
